// File: rtl/pipo_shift.sv
// Parallel-in/parallel-out shift register: sync load, hold, shift left/right, rotate left.
// Define PIPO_SHIFT_ARITH_EN to make mode 10 an arithmetic (sign-preserving) right shift.

module pipo_shift_cell (
    input  logic       i_load,
    input  logic [1:0] i_mode,
    input  logic       i_d,
    input  logic       i_q,
    input  logic       i_shl_in,
    input  logic       i_shr_in,
    input  logic       i_rol_in,
    output logic       o_next
);
    always_comb begin
        o_next = i_q;
        if (i_load) begin
            o_next = i_d;
        end else begin
            unique case (i_mode)
                2'b00:   o_next = i_q;
                2'b01:   o_next = i_shl_in;
                2'b10:   o_next = i_shr_in;
                default: o_next = i_rol_in;
            endcase
        end
    end
endmodule

module pipo_shift #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       shift_en,
    output logic [WIDTH-1:0] data_out
);
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_shl_in;
    logic [WIDTH-1:0] w_shr_in;
    logic [WIDTH-1:0] w_rol_in;
    logic             w_msb_fill;

`ifdef PIPO_SHIFT_ARITH_EN
    assign w_msb_fill = r_q[WIDTH-1];
`else
    assign w_msb_fill = 1'b0;
`endif

    // Each bit only needs its two neighbours; the ends get the fill / wrap bits.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign w_shl_in[gi] = 1'b0;
                assign w_rol_in[gi] = r_q[WIDTH-1];
            end else begin : g_mid_lo
                assign w_shl_in[gi] = r_q[gi-1];
                assign w_rol_in[gi] = r_q[gi-1];
            end
            if (gi == WIDTH-1) begin : g_msb
                assign w_shr_in[gi] = w_msb_fill;
            end else begin : g_mid_hi
                assign w_shr_in[gi] = r_q[gi+1];
            end

            pipo_shift_cell u_cell (
                .i_load   (load),
                .i_mode   (shift_en),
                .i_d      (data_in[gi]),
                .i_q      (r_q[gi]),
                .i_shl_in (w_shl_in[gi]),
                .i_shr_in (w_shr_in[gi]),
                .i_rol_in (w_rol_in[gi]),
                .o_next   (w_next[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign data_out = r_q;
endmodule

// File: tb/tb_pipo_shift.sv
// Directed + random bench for pipo_shift; word-level model feeds an expected-value queue.

module tb_pipo_shift;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [1:0]   shift_en = 2'b00;
    logic [W-1:0] data_out;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] model = '0;
    logic [W-1:0] expq[$];

    always #5 clk = ~clk;

    pipo_shift #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .data_in  (data_in),
        .shift_en (shift_en),
        .data_out (data_out)
    );

    function automatic logic [W-1:0] nxt(input logic [W-1:0] cur, input logic r, input logic l,
                                         input logic [W-1:0] d, input logic [1:0] m);
        if (r) return '0;
        if (l) return d;
        case (m)
            2'b00: return cur;
            2'b01: return cur << 1;
`ifdef PIPO_SHIFT_ARITH_EN
            2'b10: return W'($signed(cur) >>> 1);
`else
            2'b10: return cur >> 1;
`endif
            default: return {cur[W-2:0], cur[W-1]};
        endcase
    endfunction

    // Drive one cycle of inputs, queue the model's prediction, compare after the edge.
    task automatic step(input logic r, input logic l, input logic [W-1:0] d,
                        input logic [1:0] m, input string tag);
        logic [W-1:0] exp;
        reset = r; load = l; data_in = d; shift_en = m;
        model = nxt(model, r, l, d, m);
        expq.push_back(model);
        @(posedge clk);
        #1;
        exp = expq.pop_front();
        checks++;
        assert (data_out === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, data_out, exp);
        end
    endtask

    task automatic cc(input string tag, input logic [W-1:0] exp);
        checks++;
        assert (data_out === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, data_out, exp);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        // reset overrides load
        step(1'b1, 1'b1, 16'h8E16, 2'b00, "rst_edge0");
        step(1'b1, 1'b1, 16'h8E16, 2'b00, "rst_edge1");
        cc("reset_val", 16'h0000);
        step(1'b0, 1'b1, 16'h8E16, 2'b00, "rst_release");
        cc("load_after_rst", 16'h8E16);

        // load wins over shift and re-captures every cycle
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h8E16, 2'b01, "load_prio");
        cc("load_prio_const", 16'h8E16);
        step(1'b0, 1'b1, 16'h1234, 2'b11, "load_track0");
        step(1'b0, 1'b1, 16'hABCD, 2'b10, "load_track1");
        cc("load_track_val", 16'hABCD);

        // shift left
        step(1'b0, 1'b1, 16'h8E16, 2'b00, "shl_load");
        step(1'b0, 1'b0, 16'hFFFF, 2'b01, "shl_1");
        cc("shl_1_const", 16'h1C2C);
        for (int i = 1; i < W; i++) step(1'b0, 1'b0, W'($urandom), 2'b01, "shl_n");
        cc("shl_16_const", 16'h0000);

        // shift right, negative then positive operand
        step(1'b0, 1'b1, 16'h8E16, 2'b00, "shr_load");
        step(1'b0, 1'b0, 16'h0000, 2'b10, "shr_1");
`ifdef PIPO_SHIFT_ARITH_EN
        cc("shr_neg_const", 16'hC70B);
`else
        cc("shr_neg_const", 16'h470B);
`endif
        step(1'b0, 1'b1, 16'h4E16, 2'b00, "shr_load_pos");
        step(1'b0, 1'b0, 16'h0000, 2'b10, "shr_pos");
        cc("shr_pos_const", 16'h270B);

        // rotate then hold
        step(1'b0, 1'b1, 16'h8E16, 2'b00, "rol_load");
        step(1'b0, 1'b0, 16'h5555, 2'b11, "rol_1");
        cc("rol_1_const", 16'h1C2D);
        for (int i = 1; i < W; i++) step(1'b0, 1'b0, W'($urandom), 2'b11, "rol_n");
        cc("rol_16_const", 16'h8E16);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, W'($urandom), 2'b00, "hold");
        cc("hold_const", 16'h8E16);

        // reset while rotating
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000, 2'b11, "mid_rol");
        step(1'b1, 1'b0, 16'h0000, 2'b11, "mid_rst");
        cc("mid_rst_const", 16'h0000);
        step(1'b0, 1'b0, 16'h0000, 2'b11, "post_rst");
        cc("post_rst_const", 16'h0000);

        // random mix
        for (int i = 0; i < 60; i++)
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0),
                 W'($urandom), 2'($urandom), "random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
